// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame parser: FSM states, error codes,
// default SOF marker and the CRC-8 step used when UART_FRAME_CRC8_EN is set.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_SEND    = 3'd4
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_LEN_BAD = 3'd1;
    localparam logic [2:0] ERR_CHK_BAD = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_OVERRUN = 3'd4;

    localparam logic [7:0] SOF_DEFAULT = 8'h55;
    localparam logic [7:0] CRC8_POLY   = 8'h07;

    // One byte of CRC-8, MSB first, no reflection.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] c;
        c = crc ^ din;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_frame_chk.sv
// Frame check accumulator: additive sum, or CRC-8 when UART_FRAME_CRC8_EN is defined.
// load restarts the accumulation with din as the first byte; upd folds in din.
module uart_frame_chk
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic       upd,
    input  logic [7:0] din,
    output logic [7:0] acc
);

    logic [7:0] seed;
    logic [7:0] nxt;

    // Seed is zero on load so the first byte goes through the same step.
    always_comb seed = load ? 8'h00 : acc;

`ifdef UART_FRAME_CRC8_EN
    // Bytewise CRC-8 update.
    always_comb nxt = crc8_step(seed, din);
`else
    // Modulo-256 sum update.
    always_comb nxt = seed + din;
`endif

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 8'h00;
        end else if (clr) begin
            acc <= 8'h00;
        end else if (load || upd) begin
            acc <= nxt;
        end
    end

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Assembles SOF/LEN/payload/CHK frames from UART bytes, buffers the payload and
// streams it out on valid/ready once the check byte verifies.
// Build option: UART_FRAME_CRC8_EN selects CRC-8 instead of the additive check.
module uart_rx_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0]  SOF_BYTE     = SOF_DEFAULT,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TIMEOUT_CLKS = 86810
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_done,
    output logic [7:0]                   m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last,
    output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
    output logic                         frame_ok,
    output logic                         err_pulse,
    output logic [2:0]                   err_code
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TMO_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]   len_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [7:0]         m_data_d;
    logic               m_valid_d, m_last_d, frame_ok_d, err_pulse_d;
    logic [2:0]         err_code_d;
    logic               chk_clr, chk_load, chk_upd, mem_we;
    logic [7:0]         acc;
    logic [7:0]         mem_q [MAX_LEN];

    uart_frame_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (chk_clr),
        .load  (chk_load),
        .upd   (chk_upd),
        .din   (rx_data),
        .acc   (acc)
    );

    // Payload buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    // Next-state, pointer, timer and registered-output logic.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        len_d       = frame_len;
        tmo_d       = tmo_q;
        frame_ok_d  = 1'b0;
        err_pulse_d = 1'b0;
        err_code_d  = err_code;
        chk_clr     = 1'b0;
        chk_load    = 1'b0;
        chk_upd     = 1'b0;
        mem_we      = 1'b0;

        // Inter-byte timer; an arriving byte always beats expiry.
        if (state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CHK) begin
            if (rx_done) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_W'(TIMEOUT_CLKS - 1)) begin
                tmo_d       = '0;
                state_d     = ST_IDLE;
                err_pulse_d = 1'b1;
                err_code_d  = ERR_TIMEOUT;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                chk_clr = 1'b1;
                tmo_d   = '0;
                if (rx_done && rx_data == SOF_BYTE) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_done) begin
                    if (rx_data == 8'h00 || rx_data > 8'(MAX_LEN)) begin
                        state_d     = ST_IDLE;
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_LEN_BAD;
                    end else begin
                        len_d    = LEN_W'(rx_data);
                        wr_ptr_d = '0;
                        chk_load = 1'b1;
                        state_d  = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_done) begin
                    mem_we   = 1'b1;
                    chk_upd  = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (LEN_W'(wr_ptr_q) == frame_len - LEN_W'(1)) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (rx_done) begin
                    if (rx_data == acc) begin
                        state_d    = ST_SEND;
                        rd_ptr_d   = '0;
                        frame_ok_d = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_CHK_BAD;
                    end
                end
            end
            ST_SEND: begin
                if (rx_done) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
                if (m_valid && m_ready) begin
                    if (m_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        m_valid_d = (state_d == ST_SEND);
        m_data_d  = m_valid_d ? mem_q[rd_ptr_d] : 8'h00;
        m_last_d  = m_valid_d && (LEN_W'(rd_ptr_d) == len_d - LEN_W'(1));
    end

    // State, pointers and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tmo_q     <= '0;
            frame_len <= '0;
            m_valid   <= 1'b0;
            m_data    <= 8'h00;
            m_last    <= 1'b0;
            frame_ok  <= 1'b0;
            err_pulse <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tmo_q     <= tmo_d;
            frame_len <= len_d;
            m_valid   <= m_valid_d;
            m_data    <= m_data_d;
            m_last    <= m_last_d;
            frame_ok  <= frame_ok_d;
            err_pulse <= err_pulse_d;
            err_code  <= err_code_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Self-checking bench for uart_rx_frame_parser: directed frames plus randomized
// frames checked against a frame-level reference model and a beat scoreboard.
module tb_uart_rx_frame_parser;
    import uart_pkg::*;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned TMO     = 100;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk;
    logic             rst_n;
    logic [7:0]       rx_data;
    logic             rx_done;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic [LEN_W-1:0] frame_len;
    logic             frame_ok;
    logic             err_pulse;
    logic [2:0]       err_code;

    uart_rx_frame_parser #(
        .SOF_BYTE     (8'h55),
        .MAX_LEN      (MAX_LEN),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .frame_len (frame_len),
        .frame_ok  (frame_ok),
        .err_pulse (err_pulse),
        .err_code  (err_code)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] pl_q[$];
    logic [7:0] exp_q[$];
    bit         exp_last_q[$];
    int         ok_seen = 0;
    int         err_cnt = 0;
    int         ready_mode = 0;
    logic [7:0] exp_len = 8'h00;
    logic [2:0] exp_code = 3'd0;

    bit         stall_prev = 1'b0;
    logic [7:0] hold_d = 8'h00;
    logic       hold_l = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sink ready: 0 always ready, 1 stalled, 2 random.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'b0;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Beat scoreboard, stall stability and event counters.
    always @(negedge clk) begin
        if (frame_ok) ok_seen++;
        if (err_pulse) err_cnt++;
        if (stall_prev && m_valid) begin
            check("hold_data", 32'(m_data), 32'(hold_d));
            check("hold_last", 32'(m_last), 32'(hold_l));
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("stray_beat", 32'(m_valid), 32'd0);
            end else begin
                check("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
                check("beat_last", 32'(m_last), 32'(exp_last_q.pop_front()));
            end
        end
        stall_prev = m_valid && !m_ready;
        hold_d     = m_data;
        hold_l     = m_last;
    end

    // Reference check value over LEN and the first len bytes of pl_q.
    function automatic logic [7:0] ref_chk(input logic [7:0] len);
`ifdef UART_FRAME_CRC8_EN
        logic [7:0] crc;
        logic [7:0] msg[$];
        bit         fb;
        crc = 8'h00;
        msg.push_back(len);
        for (int i = 0; i < int'(len); i++) msg.push_back(pl_q[i]);
        foreach (msg[k]) begin
            for (int b = 7; b >= 0; b--) begin
                fb  = crc[7] ^ msg[k][b];
                crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return crc;
`else
        int unsigned s;
        s = 32'(len);
        for (int i = 0; i < int'(len); i++) s += 32'(pl_q[i]);
        return 8'(s % 256);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_data = 8'($urandom);
        repeat (gap) tick();
    endtask

    function automatic int pick_gap(input int gap_fix);
        return (gap_fix >= 0) ? gap_fix : int'($urandom_range(0, 3));
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        tick();
        tick();
        while ((m_valid || exp_q.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        check({tag, "_drain_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Send SOF, LEN, pl_q and chk; the model predicts the outcome.
    task automatic run_frame(input logic [7:0] len, input logic [7:0] chk, input int gap_fix,
                             input bit ovr, input string tag);
        int         ok0, er0, mode0;
        bit         good;
        logic [2:0] code;
        ok0   = ok_seen;
        er0   = err_cnt;
        mode0 = ready_mode;
        good  = 1'b0;
        code  = ERR_NONE;
        send_byte(8'h55, pick_gap(gap_fix));
        send_byte(len, pick_gap(gap_fix));
        if (len == 8'h00 || 32'(len) > MAX_LEN) begin
            code = ERR_LEN_BAD;
        end else begin
            exp_len = len;
            for (int i = 0; i < int'(len); i++) send_byte(pl_q[i], pick_gap(gap_fix));
            good = (chk == ref_chk(len));
            if (good) begin
                for (int i = 0; i < int'(len); i++) begin
                    exp_q.push_back(pl_q[i]);
                    exp_last_q.push_back(i == int'(len) - 1);
                end
            end else begin
                code = ERR_CHK_BAD;
            end
            if (ovr) ready_mode = 1;
            send_byte(chk, 0);
            check({tag, "_valid_latency"}, 32'(m_valid), 32'(good));
            check({tag, "_frame_ok"}, 32'(frame_ok), 32'(good));
            if (good && ovr) begin
                repeat (5) tick();
                check({tag, "_stalled"}, 32'(m_valid), 32'd1);
                send_byte(8'h55, 0);
                code = ERR_OVERRUN;
            end
            ready_mode = ovr ? 2 : mode0;
        end
        wait_idle(tag);
        check({tag, "_n_ok"}, 32'(ok_seen - ok0), 32'(good));
        check({tag, "_n_err"}, 32'(err_cnt - er0), 32'(code != ERR_NONE));
        if (code != ERR_NONE) exp_code = code;
        check({tag, "_err_code"}, 32'(err_code), 32'(exp_code));
        check({tag, "_frame_len"}, 32'(frame_len), 32'(exp_len));
    endtask

    initial begin
        int         n, er0, kind;
        logic [7:0] len, r;

        rst_n   = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        repeat (3) tick();
        check("reset_outputs", 32'({m_valid, m_last, frame_ok, err_pulse, m_data, frame_len, err_code}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic frame, always ready.
        pl_q = '{8'h5A, 8'hA5, 8'h3C};
        run_frame(8'd3, 8'h3E, -1, 1'b0, "t1");

        // Bad check then bad lengths.
        pl_q = '{8'hFF};
        run_frame(8'd1, 8'h01, -1, 1'b0, "t2_chk");
        run_frame(8'd0, 8'h00, -1, 1'b0, "t2_len0");
        run_frame(8'h11, 8'h00, -1, 1'b0, "t2_len17");

        // Noise, then a stalled frame that times out exactly TMO clocks after the last byte.
        er0 = err_cnt;
        send_byte(8'h00, 1);
        send_byte(8'hFF, 1);
        send_byte(8'h55, 0);
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        n = 0;
        while (!err_pulse && n < 300) begin
            tick();
            n++;
        end
        check("t3_timeout_clks", 32'(n), 32'(TMO));
        check("t3_timeout_code", 32'(err_code), 32'(ERR_TIMEOUT));
        exp_code = ERR_TIMEOUT;
        exp_len  = 8'd2;
        tick();
        check("t3_n_err", 32'(err_cnt - er0), 32'd1);
        pl_q = '{8'h07};
        run_frame(8'd1, 8'h08, -1, 1'b0, "t3_after");

        // Bytes spaced exactly TMO clocks apart must not time out.
        pl_q = '{8'h11, 8'h22};
        run_frame(8'd2, ref_chk(8'd2), int'(TMO) - 1, 1'b0, "t3_edge");

        // Stall, overrun during SEND, then random ready.
        pl_q = '{8'h81, 8'h42, 8'h24, 8'h18};
        run_frame(8'd4, ref_chk(8'd4), -1, 1'b1, "t4");

        // Reset in the middle of the payload.
        send_byte(8'h55, 0);
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        rst_n = 1'b0;
        #1;
        check("t5_reset_outputs", 32'({m_valid, m_last, frame_ok, err_pulse, m_data, frame_len, err_code}), 32'd0);
        exp_code = ERR_NONE;
        exp_len  = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pl_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
        run_frame(8'd5, ref_chk(8'd5), -1, 1'b0, "t5_after");

        // CRC vector: 55 01 00 15 passes only in the CRC build.
        pl_q = '{8'h00};
        run_frame(8'd1, 8'h15, -1, 1'b0, "t6");
`ifdef UART_FRAME_CRC8_EN
        check("t6_code", 32'(err_code), 32'(ERR_NONE));
`else
        check("t6_code", 32'(err_code), 32'(ERR_CHK_BAD));
`endif

        // Randomized frames with noise and random backpressure.
        for (int f = 0; f < 40; f++) begin
            ready_mode = int'($urandom_range(0, 1)) * 2;
            repeat ($urandom_range(0, 2)) begin
                r = 8'($urandom);
                if (r == 8'h55) r = 8'h54;
                send_byte(r, 0);
            end
            kind = int'($urandom_range(0, 9));
            pl_q.delete();
            if (kind == 0) begin
                len = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
                run_frame(len, 8'h00, -1, 1'b0, "rnd_len");
            end else begin
                len = 8'($urandom_range(1, MAX_LEN));
                for (int i = 0; i < int'(len); i++) pl_q.push_back(8'($urandom));
                r = ref_chk(len);
                if (kind <= 2) r = r ^ 8'($urandom_range(1, 255));
                run_frame(len, r, -1, 1'b0, "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
